// File: rtl/com_tracker.sv
// Per-frame target tracker fed by the colour centre-of-mass stage.
// Counts qualifying pixels per frame and waits out the divider latency before sampling the centre.
// Then smooths the track, derives velocity, detects target loss and strobes update for one cycle.
module com_tracker #(
  parameter int DIV_LATENCY = 40,
  parameter int MIN_PIXELS  = 64,
  parameter int LOST_FRAMES = 4,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        included,
  input  logic [9:0]  x_center,
  input  logic [9:0]  y_center,
  output logic [9:0]  track_x,
  output logic [9:0]  track_y,
  output logic [10:0] vel_x,
  output logic [10:0] vel_y,
  output logic        track_valid,
  output logic        lost,
  output logic        update
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

  localparam int WW = $clog2(DIV_LATENCY + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(DIV_LATENCY - 1);

  state_t          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            origin_q;
  logic            at_origin;
  logic            fs;
  logic [19:0]     pix_cnt;
  logic [19:0]     frame_count;
  logic [3:0]      miss;
  logic [4:0]      miss_inc;
  logic            present;
  logic signed [10:0] dx, dy;
  logic signed [10:0] step_x, step_y;

  // A frame starts on the first cycle of any run of (0,0) pixels.
  assign at_origin = (x == 11'd0) && (y == 10'd0);
  assign fs        = at_origin && !origin_q;

  assign present  = frame_count >= 20'(MIN_PIXELS);
  assign miss_inc = {1'b0, miss} + 5'd1;

  // The new position always lies between old track and centre, so the
  // 10-bit truncation never wraps and new - old equals the shifted step.
  assign dx     = $signed({1'b0, x_center} - {1'b0, track_x});
  assign dy     = $signed({1'b0, y_center} - {1'b0, track_y});
  assign step_x = dx >>> ALPHA_SHIFT;
  assign step_y = dy >>> ALPHA_SHIFT;

  // Remember whether the previous cycle sat on the origin.
  always_ff @(posedge clk) begin
    if (reset) origin_q <= 1'b0;
    else       origin_q <= at_origin;
  end

  // Saturating per-frame pixel count; the origin pixel already belongs to the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt     <= 20'd0;
      frame_count <= 20'd0;
    end else if (fs) begin
      frame_count <= pix_cnt;
      pix_cnt     <= {19'd0, included};
    end else if (included && (pix_cnt != 20'hFFFFF)) begin
      pix_cnt <= pix_cnt + 20'd1;
    end
  end

  // FSM and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state: a new frame start always (re)starts the latency wait.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (fs) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (fs) begin
          wcnt_d = '0;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = SAMPLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (fs) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame evaluation: acquire, smooth, or count a miss; outputs move the cycle after SAMPLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      track_x     <= 10'd360;
      track_y     <= 10'd240;
      vel_x       <= 11'd0;
      vel_y       <= 11'd0;
      track_valid <= 1'b0;
      lost        <= 1'b1;
      update      <= 1'b0;
      miss        <= 4'd15;
    end else begin
      update <= (state_q == SAMPLE);
      if (state_q == SAMPLE) begin
        if (present) begin
          miss        <= 4'd0;
          lost        <= 1'b0;
          track_valid <= 1'b1;
          if (lost) begin
            track_x <= x_center;
            track_y <= y_center;
            vel_x   <= 11'd0;
            vel_y   <= 11'd0;
          end else begin
            track_x <= track_x + step_x[9:0];
            track_y <= track_y + step_y[9:0];
            vel_x   <= step_x;
            vel_y   <= step_y;
          end
        end else begin
          miss <= miss_inc[4] ? 4'd15 : miss_inc[3:0];
          if (miss_inc >= 5'(LOST_FRAMES)) begin
            lost        <= 1'b1;
            track_valid <= 1'b0;
            vel_x       <= 11'd0;
            vel_y       <= 11'd0;
          end
        end
      end
    end
  end

endmodule

// File: doc/com_tracker.md
# com_tracker

Downstream consumer of the colour centre-of-mass stage. Each frame it counts qualifying pixels from the pixel stream and waits out the centre-of-mass divider latency. It then samples the per-frame centre, applies exponential smoothing and derives per-frame velocity. It also flags target loss when too few pixels qualify for several consecutive frames, and presents the smoothed track to the servo/motion logic with a one-cycle update strobe.

## Interface
- DIV_LATENCY, 40: cycles from frame start until x_center/y_center reflect the just-finished frame.
- MIN_PIXELS, 64: minimum included-pixel count for a frame to count as "target present".
- LOST_FRAMES, 4: consecutive absent frames before `lost` asserts (range 1..15).
- ALPHA_SHIFT, 2: smoothing factor = 1/2^ALPHA_SHIFT (range 0..4; 0 = no smoothing).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- x  in  11  current pixel column, same stream as the centre-of-mass stage.
- y  in  10  current pixel row.
- included  in  1  pixel qualified by the centre-of-mass stage.
- x_center  in  10  centre-of-mass x result.
- y_center  in  10  centre-of-mass y result.
- track_x  out  10  smoothed x position.
- track_y  out  10  smoothed y position.
- vel_x  out  11  signed two's-complement per-frame delta of track_x.
- vel_y  out  11  signed two's-complement per-frame delta of track_y.
- track_valid  out  1  track is locked (target present, not lost).
- lost  out  1  target absent for ≥ LOST_FRAMES frames, or never acquired.
- update  out  1  one-cycle strobe when track/vel outputs change.

## Operation
- Frame start (fs): the first cycle with x==0 && y==0 whose previous cycle did not satisfy it. Registered compare; repeated 0,0 cycles give a single fs.
- Pixel counter: 20-bit, saturating at 2^20-1, increments on `included`.
  - On fs it is reloaded to `included` of that cycle, because the 0,0 pixel belongs to the new frame.
  - Its prior value is latched into frame_count.
- FSM has three states: IDLE, WAIT, SAMPLE.
  - IDLE: on fs, latch frame_count, clear wait counter, go to WAIT.
  - WAIT: increment wait counter. When it equals DIV_LATENCY-1, go to SAMPLE. An fs during WAIT relatches frame_count, restarts the counter and stays in WAIT. The interrupted frame is discarded and does not affect the miss count.
  - SAMPLE: one cycle; evaluate frame, return to IDLE. An fs in the SAMPLE cycle is honoured: SAMPLE completes and the FSM goes directly to WAIT.
- Evaluation in SAMPLE, present = frame_count ≥ MIN_PIXELS.
  - If present and `lost`==1 (acquisition):
    - track ← center and vel ← 0.
    - miss ← 0, lost ← 0, track_valid ← 1.
  - If present and `lost`==0:
    - d = {1'b0,center} − {1'b0,track}, 11-bit signed.
    - track ← track + (d >>> ALPHA_SHIFT), arithmetic shift, truncated to 10 bits.
    - vel ← new track − old track; miss ← 0; track_valid ← 1.
  - If absent:
    - miss ← min(miss+1, 15).
    - track and vel are held.
    - If miss+1 ≥ LOST_FRAMES: lost ← 1, track_valid ← 0, vel ← 0.
- Arithmetic: the result always lies between old track and center, so no overflow or clamp is needed. The shift truncates toward −∞; for example d = −1 with shift 2 gives −1.

## Timing
- Reset values:
  - track_x=360, track_y=240.
  - vel_x=vel_y=0.
  - track_valid=0, lost=1, update=0.
  - miss=15, FSM=IDLE, counters=0.
  - The fs history register is cleared, so a 0,0 on the first post-reset cycle is an fs.
- Reset mid-frame or mid-WAIT aborts all state with no update.
- Latency:
  - SAMPLE occurs DIV_LATENCY+1 cycles after the fs cycle, counting the fs cycle as 0.
  - Outputs change, and `update`=1, on the cycle after SAMPLE.
  - `update` pulses for every evaluated frame, present or absent. It is exactly one cycle wide and never asserted during reset.
- x_center/y_center are sampled only in SAMPLE. Their values at other times are ignored.

## Test plan
- Reset, then frame with 100 included pixels, then fs with x_center=200, y_center=100 → update at fs+DIV_LATENCY+2; track=(200,100), vel=0, lost=0, track_valid=1.
- Locked at (200,100), ALPHA_SHIFT=2, next center (300,60) → track=(225,90), vel=(+25,−10). Next center (300,60) → track=(243,82), vel=(+18,−8).
- Locked, then 3 frames with 10 included pixels each, LOST_FRAMES=4 → track held, lost=0 after each. 4th such frame → lost=1, track_valid=0, vel=0. Next frame with 100 pixels and center (50,400) → track snaps to (50,400).
- fs, second fs 10 cycles later → single update at second fs+DIV_LATENCY+2, using the second frame's count. The miss count is unchanged by the dropped frame.
- x=y=0 held for 5 consecutive cycles → one fs, one update. 2^20+5 included pixels in one frame → frame_count=2^20-1, present.
- Reset asserted 20 cycles after fs → no update. Outputs show reset values (360,240, lost=1) and stay there until the next complete frame.
